// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin grant arbiter.
//   arb_state_t   : arbiter FSM state (IDLE, GRANT)
//   DEF_N_REQ     : default number of requesters
//   DEF_MAX_HOLD  : default maximum consecutive grant cycles under contention
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int DEF_N_REQ    = 4;
    localparam int DEF_MAX_HOLD = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Searches upward from ptr (wrapping) for the first requester in req that is
// not masked by excl.
//   req   : request vector
//   ptr   : index where the search starts
//   excl  : requesters to skip (the current holder when rotating)
//   win   : one-hot winner, zero when nothing qualifies
//   found : 1 when win is non-zero
module rr_pick
    import arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    input  logic [N_REQ-1:0] excl,
    output logic [N_REQ-1:0] win,
    output logic             found
);

    logic [N_REQ-1:0] req_m;
    logic [IW-1:0]    idx;

    assign req_m = req & ~excl;

    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = IW'((int'(ptr) + i) % N_REQ);
            if (!found && req_m[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin grant arbiter with a bounded hold time.
// A requester keeps its grant while it requests; once it has held for
// MAX_HOLD cycles and someone else is waiting, the grant is rotated away.
//   clk    : clock, all state updates on its rising edge
//   rst    : asynchronous active-high reset
//   req    : request vector, one bit per requester
//   gnt    : registered one-hot (or zero) grant vector
//   gnt_id : registered index of the granted requester, 0 when idle
//   busy   : registered, 1 while any grant is active
//
// state | meaning
// ------+---------------------------------------------
// IDLE  | no grant, gnt == 0
// GRANT | one requester holds the grant, gnt one-hot
module rr_grant_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    localparam int IW      = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int HW      = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    gnt_id,
    output logic             busy
);

    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    arb_state_t       state;
    logic [IW-1:0]    ptr;
    logic [HW-1:0]    hold_cnt;

    logic [N_REQ-1:0] excl;
    logic [N_REQ-1:0] win;
    logic             found;
    logic             holder_req;
    logic [IW-1:0]    win_id;

    function automatic logic [IW-1:0] inc_wrap(input logic [IW-1:0] i);
        return (int'(i) == N_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    // The holder is masked out so that "found" in GRANT means some other
    // requester is pending. ptr already points just past the holder.
    assign excl       = (state == GRANT) ? gnt : '0;
    assign holder_req = |(req & gnt);

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .excl  (excl),
        .win   (win),
        .found (found)
    );

    always_comb begin
        win_id = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win[i]) win_id = IW'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            busy     <= 1'b0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state    <= GRANT;
                        gnt      <= win;
                        gnt_id   <= win_id;
                        busy     <= 1'b1;
                        ptr      <= inc_wrap(win_id);
                        hold_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (found && (!holder_req || hold_cnt == HOLD_LAST)) begin
                        // hand over directly, no idle cycle in between
                        gnt      <= win;
                        gnt_id   <= win_id;
                        ptr      <= inc_wrap(win_id);
                        hold_cnt <= '0;
                    end else if (!holder_req) begin
                        state    <= IDLE;
                        gnt      <= '0;
                        gnt_id   <= '0;
                        busy     <= 1'b0;
                        ptr      <= inc_wrap(gnt_id);
                        hold_cnt <= '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        // sole requester: keep the grant, restart the window
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
module tb_rr_grant_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] id;
        logic       busy;
        string      nm;
    } exp_t;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       busy;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[10];

    rr_grant_arbiter #(.N_REQ(4), .MAX_HOLD(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [3:0] eg, input logic [1:0] eid, input logic eb);
        tests_run++;
        if (gnt !== eg || gnt_id !== eid || busy !== eb) begin
            tests_failed++;
            $display("FAIL %s: got gnt=%b gnt_id=%0d busy=%b, expected gnt=%b gnt_id=%0d busy=%b",
                     nm, gnt, gnt_id, busy, eg, eid, eb);
        end
    endtask

    // drive req at negedge, queue the expectation, compare just after the next posedge
    task automatic step(input logic [3:0] r, input logic [3:0] eg, input logic [1:0] eid,
                        input logic eb, input string nm);
        exp_t e;
        @(negedge clk);
        req = r;
        sb.push_back('{gnt: eg, id: eid, busy: eb, nm: nm});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s: scoreboard empty, expected an entry", nm);
        end else begin
            e = sb.pop_front();
            chk(e.nm, e.gnt, e.id, e.busy);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = 4'b0000;
        #1;
        chk("reset_async", 4'b0000, 2'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] one;
        logic [3:0] eg;
        one = 4'b0001;
        tests_run    = 0;
        tests_failed = 0;

        //            req       gnt      id    busy
        vecs[0] = '{4'b0000, 4'b0000, 2'd0, 1'b0};
        vecs[1] = '{4'b0100, 4'b0100, 2'd2, 1'b1};
        vecs[2] = '{4'b0000, 4'b0000, 2'd0, 1'b0};
        vecs[3] = '{4'b0011, 4'b0001, 2'd0, 1'b1};
        vecs[4] = '{4'b0010, 4'b0010, 2'd1, 1'b1};
        vecs[5] = '{4'b1001, 4'b1000, 2'd3, 1'b1};
        vecs[6] = '{4'b1001, 4'b1000, 2'd3, 1'b1};
        vecs[7] = '{4'b0110, 4'b0010, 2'd1, 1'b1};
        vecs[8] = '{4'b0000, 4'b0000, 2'd0, 1'b0};
        vecs[9] = '{4'b0011, 4'b0001, 2'd0, 1'b1};

        rst = 1'b1;
        req = 4'b1111;
        #1;
        chk("reset_t0", 4'b0000, 2'd0, 1'b0);
        @(posedge clk);
        #1;
        chk("reset_held_with_req", 4'b0000, 2'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0000;

        for (int i = 0; i < 10; i++) begin
            step(vecs[i].req, vecs[i].gnt, vecs[i].id, vecs[i].busy, $sformatf("vec%0d", i));
        end

        // single requester keeps its grant across the hold window
        do_reset();
        for (int c = 0; c < 12; c++) begin
            step(4'b0100, 4'b0100, 2'd2, 1'b1, $sformatf("solo_hold_c%0d", c));
        end

        // all requesting: each holder gets exactly 8 cycles, in order
        do_reset();
        for (int c = 0; c < 40; c++) begin
            eg = one << ((c / 8) % 4);
            step(4'b1111, eg, 2'((c / 8) % 4), 1'b1, $sformatf("all_req_c%0d", c));
        end
        step(4'b0000, 4'b0000, 2'd0, 1'b0, "all_req_drop");

        // holder drops, grant moves straight to the next pending requester
        do_reset();
        step(4'b1011, 4'b0001, 2'd0, 1'b1, "drop_c0");
        step(4'b1011, 4'b0001, 2'd0, 1'b1, "drop_c1");
        step(4'b1011, 4'b0001, 2'd0, 1'b1, "drop_c2");
        step(4'b1010, 4'b0010, 2'd1, 1'b1, "drop_handover");

        // return to idle from the top requester, pointer wraps to 0
        do_reset();
        step(4'b1000, 4'b1000, 2'd3, 1'b1, "wrap_grant3");
        step(4'b0000, 4'b0000, 2'd0, 1'b0, "wrap_idle");
        step(4'b1001, 4'b0001, 2'd0, 1'b1, "wrap_regrant");

        // async reset mid-grant, then arbitration restarts from pointer 0
        do_reset();
        step(4'b0010, 4'b0010, 2'd1, 1'b1, "rst_pre_grant");
        @(negedge clk);
        rst = 1'b1;
        req = 4'b0000;
        #1;
        chk("rst_mid_cycle", 4'b0000, 2'd0, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_held", 4'b0000, 2'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step(4'b0110, 4'b0010, 2'd1, 1'b1, "rst_restart");

        // sample timing around the edge: before the edge old value, after it new
        do_reset();
        @(negedge clk);
        req = 4'b0100;
        #3;
        chk("skew_2_before_edge", 4'b0000, 2'd0, 1'b0);
        #1;
        chk("skew_1_before_edge", 4'b0000, 2'd0, 1'b0);
        @(posedge clk);
        #1;
        chk("skew_0_after_edge", 4'b0100, 2'd2, 1'b1);
        @(negedge clk);
        req = 4'b0000;
        #4;
        chk("skew_1step_before_drop", 4'b0100, 2'd2, 1'b1);
        @(posedge clk);
        #1;
        chk("skew_0_after_drop", 4'b0000, 2'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
